fa8: RTL and testbench



---
 rtl/fa8_if.sv | 21 ++
 rtl/fa8.sv | 55 +++++
 tb/tb_fa8.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fa8_if.sv
// fa8 operand/result bundle.
// A/B/Select in; Sum/Cout/Overflow/Zero out.
interface fa8_if;
  logic [7:0] A;
  logic [7:0] B;
  logic       Select;
  logic [7:0] Sum;
  logic       Cout;
  logic       Overflow;
  logic       Zero;

  modport master (
    output A, B, Select,
    input  Sum, Cout, Overflow, Zero
  );

  modport slave (
    input  A, B, Select,
    output Sum, Cout, Overflow, Zero
  );
endinterface

// File: rtl/fa8.sv
// fa8: registered 8-bit ripple-carry add/sub.
// Ports: clk, rst (sync high), bus (fa8_if.slave).
module fa8 (
  input  logic  clk,
  input  logic  rst,
  fa8_if.slave  bus
);

  logic [7:0] w_bx;
  logic [8:0] w_c;
  logic [7:0] w_s;
  logic       w_ovf;
  logic       w_zero;

  logic [7:0] r_sum;
  logic       r_cout;
  logic       r_ovf;
  logic       r_zero;

  // Subtract = A + ~B + 1.
  assign w_bx   = bus.B ^ {8{bus.Select}};
  assign w_c[0] = bus.Select;

  for (genvar gi = 0; gi < 8; gi++) begin : g_cell
    assign w_s[gi]   = bus.A[gi] ^ w_bx[gi]
                     ^ w_c[gi];
    assign w_c[gi+1] = (bus.A[gi] & w_bx[gi])
                     | (w_c[gi]
                        & (bus.A[gi] ^ w_bx[gi]));
  end

  // Signed overflow: carry into vs out of MSB.
  assign w_ovf  = w_c[7] ^ w_c[8];
  assign w_zero = ~|w_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum  <= 8'h00;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b1;
    end else begin
      r_sum  <= w_s;
      r_cout <= w_c[8];
      r_ovf  <= w_ovf;
      r_zero <= w_zero;
    end
  end

  assign bus.Sum      = r_sum;
  assign bus.Cout     = r_cout;
  assign bus.Overflow = r_ovf;
  assign bus.Zero     = r_zero;

endmodule

// File: tb/tb_fa8.sv
// tb_fa8: random + directed check of fa8.
// Packs {Overflow,Zero,Cout,Sum} vs model.
module tb_fa8;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  fa8_if u_if ();

  fa8 u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [10:0] RST_EXP =
    {1'b0, 1'b1, 1'b0, 8'h00};

  task automatic chk(
    input string       tag,
    input logic [10:0] got,
    input logic [10:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  // Reference: integer arithmetic, no carries.
  function automatic logic [10:0] model(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic       sel
  );
    int ua, ub, ur, sa, sb, sr;
    logic c, ov, z;
    logic [7:0] s;
    ua = int'(a);
    ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    if (sel) begin
      ur = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      ur = ua + ub;
      c  = (ur > 255);
      sr = sa + sb;
    end
    s  = 8'(ur);
    ov = (sr > 127) || (sr < -128);
    z  = (s == 8'h00);
    return {ov, z, c, s};
  endfunction

  function automatic logic [10:0] obs();
    return {u_if.Overflow, u_if.Zero,
            u_if.Cout, u_if.Sum};
  endfunction

  task automatic step(
    input string      tag,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic       sel,
    input logic       r
  );
    logic [10:0] exp;
    u_if.A      = a;
    u_if.B      = b;
    u_if.Select = sel;
    rst         = r;
    exp = r ? RST_EXP : model(a, b, sel);
    @(posedge clk);
    #1;
    chk(tag, obs(), exp);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    u_if.A = 8'hFF;
    u_if.B = 8'hFF;
    u_if.Select = 1'b0;

    step("rst0", 8'hFF, 8'hFF, 1'b0, 1'b1);
    step("rst1", 8'hFF, 8'hFF, 1'b0, 1'b1);
    step("rel",  8'hFF, 8'hFF, 1'b0, 1'b0);
    chk("rel_lit", obs(),
        {1'b0, 1'b0, 1'b1, 8'hFE});

    step("add01", 8'h01, 8'h01, 1'b0, 1'b0);
    step("add80", 8'h80, 8'h00, 1'b0, 1'b0);
    step("add6A", 8'h6A, 8'h1A, 1'b0, 1'b0);
    chk("ovf_lit", obs(),
        {1'b1, 1'b0, 1'b0, 8'h84});
    step("sub30", 8'h30, 8'h01, 1'b1, 1'b0);
    step("subF8", 8'hF8, 8'h07, 1'b1, 1'b0);
    step("sub00", 8'h00, 8'h03, 1'b1, 1'b0);
    chk("brw_lit", obs(),
        {1'b0, 1'b0, 1'b0, 8'hFD});
    step("sub55", 8'h55, 8'h55, 1'b1, 1'b0);
    chk("zero_lit", obs(),
        {1'b0, 1'b1, 1'b1, 8'h00});
    step("sub80", 8'h80, 8'h01, 1'b1, 1'b0);
    chk("sovf_lit", obs(),
        {1'b1, 1'b0, 1'b1, 8'h7F});
    step("add7F", 8'h7F, 8'h01, 1'b0, 1'b0);
    step("addFF", 8'hFF, 8'h01, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      step((i == 10) ? "mid_rst" : "mid",
           8'($urandom), 8'($urandom),
           1'($urandom),
           (i == 10));
    end

    for (int i = 0; i < 1200; i++) begin
      step("rand", 8'($urandom),
           8'($urandom), 1'($urandom),
           1'b0);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
